// File: rtl/led_controller.sv
// rtl/led_controller.sv - HUB75 64x64 scan engine with dual-half 4096x4 framebuffer
module led_controller #(
    parameter int ON_TIME = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  din,
    input  logic        ce,
    input  logic        we,
    input  logic [11:0] waddr,
    output logic [4:0]  row_addr,
    output logic [5:0]  col_addr,
    output logic        oe,
    output logic        re,
    output logic        latch,
    output logic        display_clk,
    output logic [3:0]  dout_a,
    output logic [3:0]  dout_b
);

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  step_q, step_d;
    logic [4:0]  row_q, row_d;

    logic [4:0]  row_addr_q, row_addr_d;
    logic [5:0]  col_addr_q, col_addr_d;
    logic        oe_q, oe_d;
    logic        re_q, re_d;
    logic        latch_q, latch_d;
    logic        dclk_q, dclk_d;
    logic [3:0]  dout_a_q, dout_a_d;
    logic [3:0]  dout_b_q, dout_b_d;

    logic [3:0]  mem [0:4095];

    // Sequencer position (state/step/row) runs one cycle ahead of the registered pin outputs.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q + 10'd1;
        row_d      = row_q;
        row_addr_d = row_q;
        col_addr_d = col_addr_q;
        oe_d       = 1'b1;
        re_d       = 1'b0;
        latch_d    = 1'b0;
        dclk_d     = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                col_addr_d = (step_q < 10'd128) ? step_q[6:1] : 6'd63;
                re_d       = (step_q < 10'd128) && !step_q[0];
                dclk_d     = !step_q[0] && (step_q != 10'd0);
                if (step_q == 10'd128) begin
                    state_d = ST_LATCH;
                    step_d  = 10'd0;
                end
            end
            ST_LATCH: begin
                latch_d = 1'b1;
                state_d = ST_DISPLAY;
                step_d  = 10'd0;
            end
            ST_DISPLAY: begin
                oe_d = 1'b0;
                if (step_q == 10'(ON_TIME - 1)) begin
                    state_d = ST_SHIFT;
                    step_d  = 10'd0;
                    row_d   = row_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_SHIFT;
                step_d  = 10'd0;
            end
        endcase
    end

    // Read-first: the read below sees mem before this edge's write lands.
    always_comb begin
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        if (ce && re_q) begin
            dout_a_d = mem[{1'b0, row_addr_q, col_addr_q}];
            dout_b_d = mem[{1'b1, row_addr_q, col_addr_q}];
        end
    end

    always_ff @(posedge clk) begin
        if (ce && we) begin
            mem[waddr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SHIFT;
            step_q     <= 10'd0;
            row_q      <= 5'd0;
            row_addr_q <= 5'd0;
            col_addr_q <= 6'd0;
            oe_q       <= 1'b1;
            re_q       <= 1'b0;
            latch_q    <= 1'b0;
            dclk_q     <= 1'b0;
            dout_a_q   <= 4'd0;
            dout_b_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            row_q      <= row_d;
            row_addr_q <= row_addr_d;
            col_addr_q <= col_addr_d;
            oe_q       <= oe_d;
            re_q       <= re_d;
            latch_q    <= latch_d;
            dclk_q     <= dclk_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
        end
    end

    assign row_addr    = row_addr_q;
    assign col_addr    = col_addr_q;
    assign oe          = oe_q;
    assign re          = re_q;
    assign latch       = latch_q;
    assign display_clk = dclk_q;
    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;

endmodule

// File: tb/tb_led_controller.sv
// tb/tb_led_controller.sv - randomized bench for led_controller against a timeline model
module tb_led_controller;

    localparam int ON_TIME = 64;
    localparam int P       = 130 + ON_TIME;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  din = 4'd0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [11:0] waddr = 12'd0;
    logic [4:0]  row_addr;
    logic [5:0]  col_addr;
    logic        oe, re, latch, display_clk;
    logic [3:0]  dout_a, dout_b;

    led_controller #(.ON_TIME(ON_TIME)) dut (
        .clk(clk), .rst(rst), .din(din), .ce(ce), .we(we), .waddr(waddr),
        .row_addr(row_addr), .col_addr(col_addr), .oe(oe), .re(re),
        .latch(latch), .display_clk(display_clk), .dout_a(dout_a), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0] row;
        logic [5:0] col;
        logic       oe;
        logic       re;
        logic       latch;
        logic       dclk;
    } scan_t;

    logic [3:0] mdl_mem [4096];
    int         g = -1;
    logic [3:0] e_da = 4'd0;
    logic [3:0] e_db = 4'd0;
    bit         chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Outputs as a function of the number of clk edges since reset release.
    function automatic scan_t expect_scan(input int gi);
        scan_t e;
        int s;
        e = '0;
        e.oe = 1'b1;
        if (gi >= 0) begin
            s       = gi % P;
            e.row   = 5'((gi / P) % 32);
            e.col   = (s < 128) ? 6'(s / 2) : 6'd63;
            e.re    = (s < 128) && (s % 2 == 0);
            e.dclk  = (s <= 128) && (s % 2 == 0) && (s > 0);
            e.latch = (s == 129);
            e.oe    = (s < 130);
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        scan_t cur;
        cur = expect_scan(g);
        if (clk) begin
            if (!rst && ce && cur.re) begin
                e_da = mdl_mem[{1'b0, cur.row, cur.col}];
                e_db = mdl_mem[{1'b1, cur.row, cur.col}];
            end
            if (ce && we) mdl_mem[waddr] = din;
        end
        if (rst) begin
            g    = -1;
            e_da = 4'd0;
            e_db = 4'd0;
        end else begin
            g = g + 1;
        end
    end

    always @(negedge clk) begin : cmp
        scan_t e;
        if (chk_en) begin
            e = expect_scan(g);
            check("row_addr", 32'(row_addr), 32'(e.row));
            check("col_addr", 32'(col_addr), 32'(e.col));
            check("oe", 32'(oe), 32'(e.oe));
            check("re", 32'(re), 32'(e.re));
            check("latch", 32'(latch), 32'(e.latch));
            check("display_clk", 32'(display_clk), 32'(e.dclk));
            check("dout_a", 32'(dout_a), 32'(e_da));
            check("dout_b", 32'(dout_b), 32'(e_db));
        end
    end

    function automatic bit is_special(input logic [11:0] a);
        return (a == 12'h000) || (a == 12'h800) || (a == 12'h03F) || (a == 12'h041);
    endfunction

    task automatic drive_random(input bit allow_ce_off);
        ce    = allow_ce_off ? ($urandom_range(0, 3) != 0) : 1'b1;
        we    = 1'($urandom_range(0, 1));
        waddr = 12'($urandom);
        din   = 4'($urandom);
        if (is_special(waddr)) we = 1'b0;
    endtask

    initial begin
        int rises, latches, latch_len, oe_run, first_oe_run, lat0, lat1;
        int row_changes, last_row;
        bit prev_dclk, prev_latch, prev_oe, wrap_seen, oe_run_done, latch_len_done;

        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_oe", 32'(oe), 32'd1);
        check("reset_latch", 32'(latch), 32'd0);
        check("reset_dclk", 32'(display_clk), 32'd0);
        check("reset_row", 32'(row_addr), 32'd0);
        check("reset_col", 32'(col_addr), 32'd0);
        check("reset_dout", 32'({dout_a, dout_b}), 32'd0);

        for (int a = 0; a < 4096; a++) begin
            ce    = 1'b1;
            we    = 1'b1;
            waddr = 12'(a);
            case (a)
                12'h000: din = 4'h5;
                12'h800: din = 4'hA;
                12'h03F: din = 4'h7;
                12'h041: din = 4'h0;
                default: din = 4'($urandom);
            endcase
            @(negedge clk);
        end
        we  = 1'b0;
        rst = 1'b0;

        rises = 0; latches = 0; latch_len = 0; oe_run = 0; first_oe_run = -1;
        lat0 = -1; lat1 = -1; row_changes = 0; last_row = 0;
        prev_dclk = 0; prev_latch = 0; prev_oe = 1; wrap_seen = 0;
        oe_run_done = 0; latch_len_done = 0;
        for (int cyc = 0; cyc < 32 * P + 300; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (display_clk && !prev_dclk) begin
                rises++;
                if (latches == 0 && rises == 1) begin
                    check("row0_col0_dout_a", 32'(dout_a), 32'h5);
                    check("row0_col0_dout_b", 32'(dout_b), 32'hA);
                end
                if (latches == 0 && rises == 64)
                    check("row0_col63_dout_a", 32'(dout_a), 32'h7);
                if (latches == 1 && rises == 2)
                    check("gated_write_row1_col1", 32'(dout_a), 32'h0);
            end
            if (latch) latch_len++;
            if (latch && !prev_latch) begin
                if (latches == 0) begin
                    check("shift_count", 32'(rises), 32'd64);
                    lat0 = cyc;
                end
                if (latches == 1) lat1 = cyc;
                latches++;
                rises = 0;
            end
            if (!latch && prev_latch && !latch_len_done) begin
                check("latch_width", 32'(latch_len), 32'd1);
                latch_len_done = 1;
            end
            if (!oe) oe_run++;
            if (oe && !prev_oe && !oe_run_done) begin
                first_oe_run = oe_run;
                oe_run_done  = 1;
            end
            if (32'(row_addr) != last_row) begin
                check("row_step", 32'(row_addr), 32'((last_row + 1) % 32));
                if (last_row == 31 && row_addr == 5'd0) wrap_seen = 1;
                last_row = 32'(row_addr);
                row_changes++;
            end
            prev_dclk  = display_clk;
            prev_latch = latch;
            prev_oe    = oe;
            if (cyc == 10) begin
                ce = 1'b0; we = 1'b1; waddr = 12'h041; din = 4'hF;
            end else begin
                drive_random(cyc >= 2 * P);
            end
        end
        check("display_len", 32'(first_oe_run), 32'd64);
        check("row_period", 32'(lat1 - lat0), 32'd194);
        check("row_wrap", 32'(wrap_seen), 32'd1);
        check("row_changes", 32'(row_changes), 32'd33);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oe", 32'(oe), 32'd1);
        check("async_rst_re", 32'(re), 32'd0);
        check("async_rst_row_col", 32'({row_addr, col_addr}), 32'd0);
        check("async_rst_dout", 32'({dout_a, dout_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive_random(1'b1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
